// File: rtl/traffic_input_conditioner.sv
// Conditions raw push-button/switch inputs (2-flop sync + debounce FSMs) and generates a step tick.
// Latency: raw edge to debounced output is 2 + DB_CYC cycles; tick is combinational from the prescaler count.
// Backpressure: none; all outputs are free-running pulses/levels with no handshake.
//
// Ports:
//   clk        - system clock, all logic on the rising edge
//   rst        - synchronous active-low reset
//   start_raw  - asynchronous push-button (active-high)
//   sw_raw     - asynchronous 2-bit mode switches
//   tick       - one-cycle pulse every TICK_DIV cycles
//   start_db   - debounced start level; start_rise pulses on its 0->1 edge
//   sw_db      - debounced switch vector; sw_chg pulses whenever it changes
// Optional build macro: TICK_PAUSE_EN - freezes the prescaler and masks tick while start_db is high.

module traffic_input_conditioner #(
    parameter int CLK_HZ  = 125000000,
    parameter int TICK_HZ = 1,
    parameter int DB_MS   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_raw,
    input  logic [1:0] sw_raw,
    output logic       tick,
    output logic       start_db,
    output logic       start_rise,
    output logic [1:0] sw_db,
    output logic       sw_chg
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int DB_CYC   = (CLK_HZ / 1000) * DB_MS;
    localparam int TW       = $clog2(TICK_DIV);
    localparam int DW       = $clog2(DB_CYC);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYC - 1);
    localparam logic [DW-1:0] DB_ONE    = DW'(1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } db_state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers
    // ------------------------------------------------------------------
    logic [1:0] start_sync;
    logic [1:0] sw_sync1;
    logic [1:0] sw_sync2;
    logic       s_start;
    logic [1:0] s_sw;

    always_ff @(posedge clk) begin
        if (!rst) begin
            start_sync <= 2'b00;
            sw_sync1   <= 2'b00;
            sw_sync2   <= 2'b00;
        end else begin
            start_sync <= {start_sync[0], start_raw};
            sw_sync1   <= sw_raw;
            sw_sync2   <= sw_sync1;
        end
    end

    assign s_start = start_sync[1];
    assign s_sw    = sw_sync2;

    // ------------------------------------------------------------------
    // Start debouncer
    // ------------------------------------------------------------------
    db_state_t       start_st;
    logic [DW-1:0]   start_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            start_st   <= STABLE;
            start_cnt  <= '0;
            start_db   <= 1'b0;
            start_rise <= 1'b0;
        end else begin
            start_rise <= 1'b0;
            case (start_st)
                STABLE: begin
                    if (s_start != start_db) begin
                        start_st  <= PENDING;
                        start_cnt <= DB_ONE;
                    end else begin
                        start_cnt <= '0;
                    end
                end
                PENDING: begin
                    if (s_start == start_db) begin
                        // input bounced back before the window closed
                        start_st  <= STABLE;
                        start_cnt <= '0;
                    end else if (start_cnt == DB_LAST) begin
                        start_db   <= s_start;
                        start_rise <= s_start;  // only the 0->1 commit pulses
                        start_st   <= STABLE;
                        start_cnt  <= '0;
                    end else begin
                        start_cnt <= start_cnt + 1'b1;
                    end
                end
                default: begin
                    start_st  <= STABLE;
                    start_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Switch debouncer: the 2-bit vector is one unit. While pending, the
    // window keeps running across bit changes as long as the synced value
    // still differs from sw_db; the value committed is whatever is synced
    // at the final cycle.
    // ------------------------------------------------------------------
    db_state_t       sw_st;
    logic [DW-1:0]   sw_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_st  <= STABLE;
            sw_cnt <= '0;
            sw_db  <= 2'b00;
            sw_chg <= 1'b0;
        end else begin
            sw_chg <= 1'b0;
            case (sw_st)
                STABLE: begin
                    if (s_sw != sw_db) begin
                        sw_st  <= PENDING;
                        sw_cnt <= DB_ONE;
                    end else begin
                        sw_cnt <= '0;
                    end
                end
                PENDING: begin
                    if (s_sw == sw_db) begin
                        sw_st  <= STABLE;
                        sw_cnt <= '0;
                    end else if (sw_cnt == DB_LAST) begin
                        sw_db  <= s_sw;
                        sw_chg <= 1'b1;
                        sw_st  <= STABLE;
                        sw_cnt <= '0;
                    end else begin
                        sw_cnt <= sw_cnt + 1'b1;
                    end
                end
                default: begin
                    sw_st  <= STABLE;
                    sw_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Tick prescaler
    // ------------------------------------------------------------------
    logic [TW-1:0] pre_cnt;
    logic          pause;

`ifdef TICK_PAUSE_EN
    assign pause = start_db;
`else
    assign pause = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt <= '0;
        end else if (!pause) begin
            pre_cnt <= (pre_cnt == TICK_LAST) ? '0 : pre_cnt + 1'b1;
        end
    end

    // Masking with pause keeps tick low even if the count froze on its last value.
    assign tick = (pre_cnt == TICK_LAST) && !pause;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
module tb_traffic_input_conditioner;

    localparam int DIV = 10;
    localparam int DB  = 5;
`ifdef TICK_PAUSE_EN
    localparam bit PAUSE = 1'b1;
`else
    localparam bit PAUSE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_raw = 1'b0;
    logic [1:0] sw_raw = 2'b00;
    logic       tick;
    logic       start_db;
    logic       start_rise;
    logic [1:0] sw_db;
    logic       sw_chg;

    int total = 0;
    int bad   = 0;

    traffic_input_conditioner #(
        .CLK_HZ (1000),
        .TICK_HZ(100),
        .DB_MS  (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_raw (start_raw),
        .sw_raw    (sw_raw),
        .tick      (tick),
        .start_db  (start_db),
        .start_rise(start_rise),
        .sw_db     (sw_db),
        .sw_chg    (sw_chg)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: inputs reach the debouncers two edges after being
    // sampled; an output adopts the synced value once it has differed
    // from the output for DB consecutive edges. Tick fires when the
    // number of counting edges since reset is one short of a multiple of DIV.
    // ------------------------------------------------------------------
    bit       m_valid = 1'b0;
    bit       m_s1, m_s2;
    bit [1:0] m_w1, m_w2;
    bit       m_start, m_rise, m_chg;
    bit [1:0] m_sw;
    int       m_srun, m_wrun, m_active;
    bit       cur_s;
    bit [1:0] cur_w;

    always @(posedge clk) begin
        if (!rst) begin
            m_valid = 1'b1;
            m_s1 = 0; m_s2 = 0; m_w1 = 0; m_w2 = 0;
            m_start = 0; m_rise = 0; m_chg = 0; m_sw = 0;
            m_srun = 0; m_wrun = 0; m_active = 0;
        end else begin
            cur_s = m_s2;
            cur_w = m_w2;
            m_s2 = m_s1; m_s1 = start_raw;
            m_w2 = m_w1; m_w1 = sw_raw;
            if (!(PAUSE && m_start)) m_active++;
            m_rise = 0;
            m_chg  = 0;
            if (cur_s != m_start) begin
                m_srun++;
                if (m_srun == DB) begin
                    m_start = cur_s;
                    m_rise  = cur_s;
                    m_srun  = 0;
                end
            end else begin
                m_srun = 0;
            end
            if (cur_w != m_sw) begin
                m_wrun++;
                if (m_wrun == DB) begin
                    m_sw   = cur_w;
                    m_chg  = 1;
                    m_wrun = 0;
                end
            end else begin
                m_wrun = 0;
            end
        end
    end

    // Per-cycle compare against the model
    logic [5:0] got_v, exp_v;
    always @(negedge clk) begin
        if (m_valid) begin
            got_v = {tick, start_db, start_rise, sw_db, sw_chg};
            exp_v = {((m_active % DIV) == DIV - 1) && !(PAUSE && m_start),
                     m_start, m_rise, m_sw, m_chg};
            total++;
            if (got_v !== exp_v) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t {tick,db,rise,sw_db,chg} got=%b want=%b",
                         $time, got_v, exp_v);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Observe n cycles; cycle 1 is the cycle in progress when called.
    task automatic watch(input int n,
                         output int t1, output int t2, output int t3,
                         output int db_on, output int db_off,
                         output int rises, output int chg_first, output int chgs,
                         output int sw_at_chg);
        t1 = -1; t2 = -1; t3 = -1; db_on = -1; db_off = -1;
        rises = 0; chg_first = -1; chgs = 0; sw_at_chg = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (tick) begin
                if (t1 < 0) t1 = i;
                else if (t2 < 0) t2 = i;
                else if (t3 < 0) t3 = i;
            end
            if (start_db && db_on < 0) db_on = i;
            if (!start_db && db_off < 0) db_off = i;
            if (start_rise) rises++;
            if (sw_chg) begin
                chgs++;
                if (chg_first < 0) begin
                    chg_first = i;
                    sw_at_chg = int'(sw_db);
                end
            end
        end
    endtask

    int t1, t2, t3, db_on, db_off, rises, chg_first, chgs, sw_at;
    int s_hold, w_hold;

    initial begin
        // Reset: rst low across the first edge
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", int'({tick, start_db, start_rise, sw_db, sw_chg}), 0);
        step();
        rst = 1'b1;

        // Idle: ticks at cycles 10, 20, 30 after release
        watch(30, t1, t2, t3, db_on, db_off, rises, chg_first, chgs, sw_at);
        check("idle_tick1", t1, 10);
        check("idle_tick2", t2, 20);
        check("idle_tick3", t3, 30);
        check("idle_start_db", db_on, -1);
        check("idle_sw_chg", chgs, 0);

        // Clean start press: high 7 cycles later, one rise pulse
        step();
        start_raw = 1'b1;
        watch(20, t1, t2, t3, db_on, db_off, rises, chg_first, chgs, sw_at);
        check("start_rise_latency", db_on, 8);
        check("start_rise_pulses", rises, 1);

        // Release: low 7 cycles later, no pulse
        step();
        start_raw = 1'b0;
        watch(20, t1, t2, t3, db_on, db_off, rises, chg_first, chgs, sw_at);
        check("start_fall_latency", db_off, 8);
        check("start_fall_pulses", rises, 0);

        // Short glitch: 3 cycles high is rejected
        step();
        start_raw = 1'b1;
        step(); step(); step();
        start_raw = 1'b0;
        watch(20, t1, t2, t3, db_on, db_off, rises, chg_first, chgs, sw_at);
        check("glitch_start_db", db_on, -1);
        check("glitch_rise", rises, 0);

        // Switch 00->10, then 10->11 two cycles later
        step();
        sw_raw = 2'b10;
        step(); step();
        sw_raw = 2'b11;
        watch(20, t1, t2, t3, db_on, db_off, rises, chg_first, chgs, sw_at);
        check("sw_chg_latency", chg_first + 2, 8);
        check("sw_chg_value", sw_at, 3);
        check("sw_chg_pulses", chgs, 1);
        step();
        sw_raw = 2'b00;
        watch(12, t1, t2, t3, db_on, db_off, rises, chg_first, chgs, sw_at);
        check("sw_back_value", int'(sw_db), 0);

        // Reset while start pending at count 3
        step();
        start_raw = 1'b1;
        step(); step(); step(); step(); step();
        rst = 1'b0;
        start_raw = 1'b0;
        step();
        rst = 1'b1;
        watch(20, t1, t2, t3, db_on, db_off, rises, chg_first, chgs, sw_at);
        check("rst_pend_start_db", db_on, -1);
        check("rst_pend_tick", t1, 10);

        // Randomized traffic with occasional resets
        s_hold = 1;
        w_hold = 1;
        for (int c = 0; c < 4000; c++) begin
            step();
            rst = ($urandom_range(0, 399) != 0);
            if (--s_hold == 0) begin
                start_raw = ~start_raw;
                s_hold = $urandom_range(1, 12);
            end
            if (--w_hold == 0) begin
                sw_raw = 2'($urandom_range(0, 3));
                w_hold = $urandom_range(1, 12);
            end
        end
        step();
        rst = 1'b1;
        repeat (20) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
